berzerk_clk_rst_gen: RTL
========================

// Module: berzerk_clk_rst_gen
// PURPOSE
// Sits directly downstream of the 10.125 MHz rPLL output (27 MHz * 3/8) and is the sole clock/reset
// source for the Berzerk core. Sequences power-up reset against PLL lock, then derives single-cycle
// clock enables from the master clock: pixel (/2), CPU (/4) and CPU anti-phase (/4, offset half period).
// Also handles a user soft reset that restarts only the CPU.
// PARAMETERS
// PIX_DIV     2     master cycles per ce_pix; CPU_DIV must be an integer multiple of PIX_DIV
// CPU_DIV     4     master cycles per ce_cpu; even, >=2
// RST_HOLD    1024  master cycles sys_reset stays high after lock is seen (~101 us)
// CPU_RST_CE  8     ce_cpu pulses cpu_reset stays high after sys_reset release
// USE_LOCK    1     0: pll_lock ignored and treated as constantly 1
// PORTS
// clk         in   1  master clock, 10.125 MHz from the PLL
// reset       in   1  synchronous, active-high
// pll_lock    in   1  PLL lock, asynchronous; tie 1'b1 while the PLL lock pin is unrouted
// soft_reset  in   1  synchronous, already debounced, active-high; restarts the CPU only
// ce_pix      out  1  pixel clock enable, one-cycle pulse
// ce_cpu      out  1  CPU clock enable, one-cycle pulse
// ce_cpu_n    out  1  CPU anti-phase enable, one-cycle pulse
// sys_reset   out  1  reset for video, sound and IO, active-high
// cpu_reset   out  1  reset for the Z80, active-high
// ready       out  1  high in S_RUN
// BEHAVIOUR
// - Lock synchroniser: 2-FF (lock_s). Lock loss means lock_s==0 with USE_LOCK=1.
// - Reset state:
//   - state=S_WAIT_LOCK; sync FFs, div_cnt, hold_cnt and ce_cnt all =0.
//   - sys_reset=1, cpu_reset=1; ce_pix, ce_cpu, ce_cpu_n and ready all =0.
// - S_WAIT_LOCK: exit to S_HOLD when lock_s=1; clear hold_cnt on exit.
// - S_HOLD: hold_cnt++ each cycle. When hold_cnt==RST_HOLD-1, go to S_CPU_HOLD and clear div_cnt/ce_cnt.
// - S_CPU_HOLD: sys_reset=0, cpu_reset=1, enables running. ce_cnt++ on each ce_cpu.
//   Go to S_RUN on the ce_cpu pulse that makes ce_cnt==CPU_RST_CE.
// - S_RUN: sys_reset=0, cpu_reset=0, ready=1.
// - sys_reset/cpu_reset/ready are registered from the next state, so they change on the state-entry edge.
// - Divider runs only in S_CPU_HOLD and S_RUN.
//   - div_cnt counts 0..CPU_DIV-1 and wraps; it is 0 in the first cycle of S_CPU_HOLD.
//   - Enables are combinational decodes of the registered div_cnt, gated by the registered run state:
//     - ce_pix   = (div_cnt % PIX_DIV)==PIX_DIV-1
//     - ce_cpu   = div_cnt==CPU_DIV-1
//     - ce_cpu_n = div_cnt==CPU_DIV/2-1
//   - ce_cpu and ce_cpu_n are never high in the same cycle.
// - Lock loss in S_HOLD, S_CPU_HOLD or S_RUN: next state S_WAIT_LOCK.
//   sys_reset and cpu_reset go to 1 and ready to 0 on that edge. Enables stop; div_cnt clears.
// - soft_reset=1 in S_CPU_HOLD or S_RUN: next state S_CPU_HOLD with div_cnt=0 and ce_cnt=0.
//   cpu_reset=1, sys_reset stays 0, enables restart from phase 0.
//   soft_reset has no effect in S_WAIT_LOCK or S_HOLD.
// - Priority: reset > lock loss > soft_reset > normal sequencing.
// - Counter widths are $clog2 of their terminal value +1; no counter saturates or overflows past its terminal value.
// TESTING
// - Cycle k = k-th edge after reset is sampled low; defaults, pll_lock=1:
//   - lock_s=1 at k=2, S_HOLD from k=3.
//   - sys_reset falls at k=1027; cpu_reset falls at k=1059; ready rises at k=1059.
// - Enable pattern after sys_reset release:
//   - ce_pix at offsets 1,3,5,...; ce_cpu at 3,7,11,...; ce_cpu_n at 1,5,9,...
//   - Never ce_cpu and ce_cpu_n together; exactly 25% duty on each CPU enable.
// - pll_lock held 0 for 5000 cycles -> sys_reset=1, cpu_reset=1, no enables.
//   Raise pll_lock -> sys_reset falls exactly 1027 cycles later.
// - Drop pll_lock in S_RUN -> sys_reset=1 two or three edges later, enables stop and ready=0.
//   Restore pll_lock -> full RST_HOLD sequence repeats.
// - soft_reset pulse 1 cycle in S_RUN -> cpu_reset high for 32 cycles with sys_reset=0 throughout;
//   enable phase restarts at div_cnt=0. Same pulse during S_HOLD -> no effect.
// - reset asserted mid-S_CPU_HOLD -> all outputs at reset values on the next edge.
//   USE_LOCK=0 with pll_lock=0 -> sys_reset falls at k=1027-2 (S_HOLD entered at k=1).

Source files
------------

// File: rtl/berzerk_clk_rst_gen.sv
// Clock-enable and reset sequencer for the Berzerk core, fed by the 10.125 MHz PLL clock.
// Ports: clk, reset, pll_lock, soft_reset -> ce_pix, ce_cpu, ce_cpu_n, sys_reset, cpu_reset, ready.
module berzerk_clk_rst_gen #(
  parameter int PIX_DIV    = 2,
  parameter int CPU_DIV    = 4,
  parameter int RST_HOLD   = 1024,
  parameter int CPU_RST_CE = 8,
  parameter int USE_LOCK   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic soft_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_cpu_n,
  output logic sys_reset,
  output logic cpu_reset,
  output logic ready
);

  localparam int DW = $clog2(CPU_DIV - 1) + 1;
  localparam int HW = $clog2(RST_HOLD - 1) + 1;
  localparam int CW = $clog2(CPU_RST_CE) + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CPU_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CPU_DIV / 2 - 1);
  localparam logic [DW-1:0] PIX_MOD  = DW'(PIX_DIV);
  localparam logic [DW-1:0] PIX_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [CW-1:0] CE_LAST  = CW'(CPU_RST_CE);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_CPU_HOLD,
    S_RUN
  } state_t;

  state_t        state, state_nxt;
  logic          lock_m, lock_s, lock_ok, run;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] ce_cnt, ce_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  assign lock_ok = (USE_LOCK != 0) ? lock_s : 1'b1;

  assign run      = (state == S_CPU_HOLD) || (state == S_RUN);
  assign ce_pix   = run && ((div_cnt % PIX_MOD) == PIX_LAST);
  assign ce_cpu   = run && (div_cnt == DIV_LAST);
  assign ce_cpu_n = run && (div_cnt == DIV_HALF);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    hold_nxt  = hold_cnt;
    ce_nxt    = ce_cnt;
    unique case (state)
      S_WAIT_LOCK: begin
        div_nxt = '0;
        if (lock_ok) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      S_HOLD: begin
        if (!lock_ok) begin
          state_nxt = S_WAIT_LOCK;
        end else if (hold_cnt == HLD_LAST) begin
          state_nxt = S_CPU_HOLD;
          div_nxt   = '0;
          ce_nxt    = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_CPU_HOLD, S_RUN: begin
        if (!lock_ok) begin
          state_nxt = S_WAIT_LOCK;
          div_nxt   = '0;
        end else if (soft_reset) begin
          state_nxt = S_CPU_HOLD;
          div_nxt   = '0;
          ce_nxt    = '0;
        end else begin
          div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          if ((state == S_CPU_HOLD) && ce_cpu) begin
            ce_nxt = ce_cnt + 1'b1;
            if (ce_nxt == CE_LAST)
              state_nxt = S_RUN;
          end
        end
      end
      default: state_nxt = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT_LOCK;
      div_cnt   <= '0;
      hold_cnt  <= '0;
      ce_cnt    <= '0;
      sys_reset <= 1'b1;
      cpu_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      hold_cnt  <= hold_nxt;
      ce_cnt    <= ce_nxt;
      sys_reset <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_HOLD);
      cpu_reset <= (state_nxt != S_RUN);
      ready     <= (state_nxt == S_RUN);
    end
  end

endmodule
